// File: rtl/wbuf_pkg.sv
// Shared definitions for the ping-pong weight buffer: bank state encoding and
// the functions that derive slice grouping and slice-id width from the array shape.
package wbuf_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FULL  = 2'd1,
        BANK_DRAIN = 2'd2
    } bank_state_t;

    // Number of write-port words that make up one PE row of weights.
    function automatic int calc_group_size(input int data_width, input int array_m,
                                           input int mem_data_width);
        return (data_width * array_m) / mem_data_width;
    endfunction

    // Slice id = row index bits plus, when a row spans several words, word-in-row bits.
    function automatic int calc_buf_id_w(input int array_n, input int group_size);
        return $clog2(array_n) + ((group_size == 1) ? 0 : $clog2(group_size));
    endfunction

endpackage

// File: rtl/wbuf_bank_ctrl.sv
// Ping-pong bank bookkeeping: per-bank EMPTY/FULL/DRAIN state, write and read
// pointers, the drain countdown that covers reads still skewing down the rows.
module wbuf_bank_ctrl
    import wbuf_pkg::*;
#(
    parameter int ARRAY_N = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic write_req,
    input  logic write_done,
    input  logic read_done,
    output logic write_ready,
    output logic read_ready,
    output logic wp,
    output logic rp,
    output logic write_err
);

    localparam int CNT_W = $clog2(ARRAY_N + 1);

    bank_state_t      state_q [2];
    bank_state_t      state_d [2];
    logic             wp_q, wp_d;
    logic             rp_q, rp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    assign write_ready = (state_q[wp_q] == BANK_EMPTY);
    assign read_ready  = (state_q[rp_q] == BANK_FULL);
    assign wp          = wp_q;
    assign rp          = rp_q;
    assign write_err   = err_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            wp_q       <= 1'b0;
            rp_q       <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // The write side only touches bank wp (EMPTY) and the read side only bank rp
    // (FULL/DRAIN), so both dones can land in one cycle without interfering.
    // NOTE: every variable gets its hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if ((write_req || write_done) && !write_ready) begin
            err_d = 1'b1;
        end

        if (write_done && write_ready) begin
            state_d[wp_q] = BANK_FULL;
            wp_d          = ~wp_q;
        end

        if (state_q[rp_q] == BANK_DRAIN) begin
            if (cnt_q <= CNT_W'(1)) begin
                state_d[rp_q] = BANK_EMPTY;
                rp_d          = ~rp_q;
                cnt_d         = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (read_done && read_ready) begin
            state_d[rp_q] = BANK_DRAIN;
            cnt_d         = CNT_W'(ARRAY_N);
        end
    end

endmodule

// File: rtl/wbuf_ram.sv
// Simple dual-port RAM slice: one write port, one registered read port with
// 1-cycle latency; only the read output register is reset.
module wbuf_ram #(
    parameter int WIDTH      = 64,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [1 << ADDR_WIDTH];

    // NOTE: the storage array is deliberately not reset so it maps onto block RAM;
    // contents survive a reset and only the output register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/wbuf_pingpong.sv
// Double-buffered weight store for an ARRAY_N x ARRAY_M PE array: narrow writes fill
// one bank while the other is read row by row with a one-cycle-per-row skew.
module wbuf_pingpong
    import wbuf_pkg::*;
#(
    parameter int  ARRAY_N        = 64,
    parameter int  ARRAY_M        = 64,
    parameter int  DATA_WIDTH     = 16,
    parameter int  MEM_DATA_WIDTH = 64,
    parameter int  BUF_ADDR_WIDTH = 9,
    localparam int GROUP_SIZE     = calc_group_size(DATA_WIDTH, ARRAY_M, MEM_DATA_WIDTH),
    localparam int BUF_ID_W       = calc_buf_id_w(ARRAY_N, GROUP_SIZE),
    localparam int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W,
    localparam int BUF_DATA_WIDTH = ARRAY_N * ARRAY_M * DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_write_req,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
    input  logic [MEM_DATA_WIDTH-1:0] mem_write_data,
    output logic                      mem_write_ready,
    input  logic                      mem_write_done,
    input  logic                      buf_read_req,
    input  logic [BUF_ADDR_WIDTH-1:0] buf_read_addr,
    output logic                      buf_read_ready,
    input  logic                      buf_read_done,
    output logic [BUF_DATA_WIDTH-1:0] buf_read_data,
    output logic [ARRAY_N-1:0]        buf_read_valid,
    output logic                      write_err
);

    localparam int NUM_SLICES = ARRAY_N * GROUP_SIZE;

    if ((DATA_WIDTH * ARRAY_M) % MEM_DATA_WIDTH != 0) begin : g_bad_cfg
        $error("DATA_WIDTH*ARRAY_M must be a multiple of MEM_DATA_WIDTH");
    end

    typedef struct packed {
        logic                      valid;
        logic                      bank;
        logic [BUF_ADDR_WIDTH-1:0] addr;
    } rd_tag_t;

    logic                      wp, rp;
    logic                      write_fire, read_fire;
    logic [BUF_ID_W-1:0]       wr_slice;
    logic [BUF_ADDR_WIDTH-1:0] wr_entry;
    rd_tag_t                   pipe [ARRAY_N];

    wbuf_bank_ctrl #(.ARRAY_N(ARRAY_N)) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .write_req   (mem_write_req),
        .write_done  (mem_write_done),
        .read_done   (buf_read_done),
        .write_ready (mem_write_ready),
        .read_ready  (buf_read_ready),
        .wp          (wp),
        .rp          (rp),
        .write_err   (write_err)
    );

    assign write_fire = mem_write_req && mem_write_ready;
    assign read_fire  = buf_read_req && buf_read_ready;
    assign wr_slice   = mem_write_addr[BUF_ID_W-1:0];
    assign wr_entry   = mem_write_addr[MEM_ADDR_WIDTH-1:BUF_ID_W];

    // Stage n carries the request to row n; the bank tag travels with it so a
    // read issued just before a bank swap still returns the old bank's weights.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int n = 0; n < ARRAY_N; n++) begin
                pipe[n] <= '0;
            end
            buf_read_valid <= '0;
        end else begin
            pipe[0] <= '{valid: read_fire, bank: rp, addr: buf_read_addr};
            for (int n = 1; n < ARRAY_N; n++) begin
                pipe[n] <= pipe[n-1];
            end
            for (int n = 0; n < ARRAY_N; n++) begin
                buf_read_valid[n] <= pipe[n].valid;
            end
        end
    end

    // Each slice RAM holds both banks; the bank bit is the address MSB.
    for (genvar s = 0; s < NUM_SLICES; s++) begin : g_slice
        localparam int ROW = s / GROUP_SIZE;
        logic wr_en;

        assign wr_en = write_fire && (wr_slice == BUF_ID_W'(s));

        wbuf_ram #(
            .WIDTH      (MEM_DATA_WIDTH),
            .ADDR_WIDTH (BUF_ADDR_WIDTH + 1)
        ) u_ram (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en),
            .wr_addr ({wp, wr_entry}),
            .wr_data (mem_write_data),
            .rd_en   (pipe[ROW].valid),
            .rd_addr ({pipe[ROW].bank, pipe[ROW].addr}),
            .rd_data (buf_read_data[s*MEM_DATA_WIDTH +: MEM_DATA_WIDTH])
        );
    end

endmodule
